// File: rtl/nv_nvdla_sdp_rd_arb_pkg.sv
// Shared types and widths for the SDP read-port arbiter: payload layout,
// client ids and the tag recorded for every request issued to MCIF.
package nv_nvdla_sdp_rd_arb_pkg;

  localparam int NREQ      = 4;
  localparam int REQ_PD_W  = 79;
  localparam int RSP_PD_W  = 257;
  localparam int TAG_DEPTH = 8;

  // Request payload layout: [63:0] address, [78:64] size in 32B units minus 1
  localparam int ADDR_LSB  = 0;
  localparam int ADDR_W    = 64;
  localparam int SIZE_LSB  = 64;
  localparam int SIZE_W    = 15;

  localparam int CNT_W     = $clog2(TAG_DEPTH) + 1;

  typedef enum logic [1:0] {
    MRDMA = 2'd0,
    BRDMA = 2'd1,
    NRDMA = 2'd2,
    ERDMA = 2'd3
  } client_id_e;

  typedef struct packed {
    client_id_e        id;
    logic [SIZE_W-1:0] size;
  } tag_t;

  function automatic logic [SIZE_W-1:0] req_size(input logic [REQ_PD_W-1:0] pd);
    return pd[SIZE_LSB +: SIZE_W];
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_rd_arb_if.sv
// Client-side and MCIF-side handshake bundle of the SDP read arbiter.
// Every channel is valid/ready: a beat transfers on a clock edge where both
// are high; valid and payload must hold stable until ready is seen.
interface nv_nvdla_sdp_rd_arb_if;
  import nv_nvdla_sdp_rd_arb_pkg::*;

  logic [NREQ-1:0]          cl_req_valid;
  logic [NREQ-1:0]          cl_req_ready;
  logic [NREQ*REQ_PD_W-1:0] cl_req_pd;
  logic [NREQ-1:0]          cl_rsp_valid;
  logic [NREQ-1:0]          cl_rsp_ready;
  logic [RSP_PD_W-1:0]      cl_rsp_pd;
  logic                     sdp2mcif_rd_req_valid;
  logic                     sdp2mcif_rd_req_ready;
  logic [REQ_PD_W-1:0]      sdp2mcif_rd_req_pd;
  logic                     mcif2sdp_rd_rsp_valid;
  logic                     mcif2sdp_rd_rsp_ready;
  logic [RSP_PD_W-1:0]      mcif2sdp_rd_rsp_pd;

  modport slave (
    input  cl_req_valid, cl_req_pd, cl_rsp_ready,
    input  sdp2mcif_rd_req_ready, mcif2sdp_rd_rsp_valid, mcif2sdp_rd_rsp_pd,
    output cl_req_ready, cl_rsp_valid, cl_rsp_pd,
    output sdp2mcif_rd_req_valid, sdp2mcif_rd_req_pd, mcif2sdp_rd_rsp_ready
  );

  modport master (
    output cl_req_valid, cl_req_pd, cl_rsp_ready,
    output sdp2mcif_rd_req_ready, mcif2sdp_rd_rsp_valid, mcif2sdp_rd_rsp_pd,
    input  cl_req_ready, cl_rsp_valid, cl_rsp_pd,
    input  sdp2mcif_rd_req_valid, sdp2mcif_rd_req_pd, mcif2sdp_rd_rsp_ready
  );

endinterface

// File: rtl/nv_nvdla_sdp_rd_tag_fifo.sv
// Flop-based FIFO of outstanding request tags (client id + beat count).
// Push is ignored when full and pop when empty; the owner never relies on either.
module nv_nvdla_sdp_rd_tag_fifo
  import nv_nvdla_sdp_rd_arb_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  tag_t                     push_tag_i,
  input  logic                     pop_i,
  output tag_t                     head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  tag_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
    end
  end

endmodule

// File: rtl/nv_nvdla_sdp_rd_arb.sv
// Round-robin merge of the four SDP read DMA clients onto the single MCIF
// read port, with in-order response routing driven by a tag FIFO.
module nv_nvdla_sdp_rd_arb
  import nv_nvdla_sdp_rd_arb_pkg::*;
(
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  nv_nvdla_sdp_rd_arb_if.slave rd_if,
  output logic [CNT_W-1:0]     rd_outstanding,
  output logic                 rd_rsp_err
);

  logic                out_vld_q, out_vld_d;
  logic [REQ_PD_W-1:0] out_pd_q, out_pd_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [SIZE_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                err_q, err_d;

  logic                gnt_found;
  logic [1:0]          gnt_id;
  logic [REQ_PD_W-1:0] gnt_pd;
  logic                out_free, gnt_en, accept;
  logic [NREQ-1:0]     req_ready_c;

  tag_t                push_tag, head_tag;
  logic [1:0]          head_id;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0]    fifo_count;

  logic [NREQ-1:0]     rsp_valid_c;
  logic                rsp_ready_c, rsp_hs, last_beat;

  // Search begins at the client after the last winner
  always_comb begin
    logic [1:0] idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!gnt_found && rd_if.cl_req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  always_comb begin
    gnt_pd = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id == 2'(k)) gnt_pd = rd_if.cl_req_pd[k*REQ_PD_W +: REQ_PD_W];
    end
  end

  // A grant needs room both in the output register and in the tag FIFO
  assign out_free = ~out_vld_q | rd_if.sdp2mcif_rd_req_ready;
  assign gnt_en   = ~nvdla_core_rst & out_free & ~fifo_full;
  assign accept   = gnt_en & gnt_found;

  always_comb begin
    req_ready_c = '0;
    if (accept) req_ready_c[gnt_id] = 1'b1;
  end

  assign push_tag.id   = client_id_e'(gnt_id);
  assign push_tag.size = req_size(gnt_pd);

  nv_nvdla_sdp_rd_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i      (nvdla_core_clk),
    .rst_i      (nvdla_core_rst),
    .push_i     (accept),
    .push_tag_i (push_tag),
    .pop_i      (fifo_pop),
    .head_o     (head_tag),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // Responses with no tag outstanding are swallowed so MCIF never stalls
  assign head_id     = head_tag.id;
  assign rsp_ready_c = ~nvdla_core_rst & (fifo_empty | rd_if.cl_rsp_ready[head_id]);
  assign rsp_hs      = rd_if.mcif2sdp_rd_rsp_valid & rsp_ready_c;
  assign last_beat   = (beat_cnt_q == head_tag.size);
  assign fifo_pop    = rsp_hs & ~fifo_empty & last_beat;

  always_comb begin
    rsp_valid_c = '0;
    if (rd_if.mcif2sdp_rd_rsp_valid && !fifo_empty && !nvdla_core_rst)
      rsp_valid_c[head_id] = 1'b1;
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_pd_d   = out_pd_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    if (accept) begin
      out_vld_d = 1'b1;
      out_pd_d  = gnt_pd;
      rr_ptr_d  = gnt_id + 2'd1;
    end else if (rd_if.sdp2mcif_rd_req_ready) begin
      out_vld_d = 1'b0;
    end
    if (rsp_hs) begin
      if (fifo_empty) begin
        err_d = 1'b1;
      end else if (last_beat) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + SIZE_W'(1);
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      out_vld_q  <= 1'b0;
      out_pd_q   <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_pd_q   <= out_pd_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign rd_if.cl_req_ready          = req_ready_c;
  assign rd_if.sdp2mcif_rd_req_valid = out_vld_q;
  assign rd_if.sdp2mcif_rd_req_pd    = out_pd_q;
  assign rd_if.cl_rsp_valid          = rsp_valid_c;
  assign rd_if.cl_rsp_pd             = rd_if.mcif2sdp_rd_rsp_pd;
  assign rd_if.mcif2sdp_rd_rsp_ready = rsp_ready_c;
  assign rd_outstanding              = fifo_count;
  assign rd_rsp_err                  = err_q;

endmodule

// File: tb/tb_nv_nvdla_sdp_rd_arb.sv
// Directed bench for the SDP read arbiter: request and response scoreboards
// fed from the stimulus, checked by a negedge monitor and inline assertions.
module tb_nv_nvdla_sdp_rd_arb;
  import nv_nvdla_sdp_rd_arb_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] rd_outstanding;
  logic             rd_rsp_err;

  nv_nvdla_sdp_rd_arb_if bus();

  nv_nvdla_sdp_rd_arb dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .rd_if          (bus),
    .rd_outstanding (rd_outstanding),
    .rd_rsp_err     (rd_rsp_err)
  );

  always #5 clk = ~clk;

  logic [REQ_PD_W-1:0]   exp_req_q[$];
  logic [RSP_PD_W+1:0]   exp_rsp_q[$];
  int                    pend_id_q[$];
  int                    pend_sz_q[$];
  int                    sent [NREQ];
  int                    n_cmp = 0;
  int                    n_fail = 0;

  task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_cmp++;
    n_fail++;
    $error("FAIL %s: observed a transfer, expected none", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [REQ_PD_W-1:0] mk_pd(input int c, input int n, input int sz);
    logic [63:0] a;
    a = 64'h1000_0000 + 64'(c) * 64'h10_0000 + 64'(n) * 64'h20;
    return {15'(sz), a};
  endfunction

  function automatic logic [RSP_PD_W-1:0] rnd_data();
    logic [RSP_PD_W-1:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    d[256] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  task automatic drive_pds(input int sz);
    for (int c = 0; c < NREQ; c++) bus.cl_req_pd[c*REQ_PD_W +: REQ_PD_W] = mk_pd(c, sent[c], sz);
  endtask

  // Called at negedge: expects client gid to be granted on the coming edge
  task automatic expect_grant(input int gid, input int sz);
    check("gnt_onehot", bus.cl_req_ready, 300'(4'b0001 << gid));
    exp_req_q.push_back(mk_pd(gid, sent[gid], sz));
    pend_id_q.push_back(gid);
    pend_sz_q.push_back(sz);
  endtask

  task automatic run_grants(input int start, input int n, input int sz);
    for (int i = 0; i < n; i++) begin
      int gid;
      gid = (start + i) % NREQ;
      mid();
      expect_grant(gid, sz);
      tick();
      sent[gid]++;
      drive_pds(sz);
    end
  endtask

  task automatic drain();
    while (pend_id_q.size() > 0) begin
      int id, sz;
      logic [RSP_PD_W-1:0] d;
      id = pend_id_q.pop_front();
      sz = pend_sz_q.pop_front();
      for (int b = 0; b <= sz; b++) begin
        d = rnd_data();
        bus.mcif2sdp_rd_rsp_valid = 1'b1;
        bus.mcif2sdp_rd_rsp_pd    = d;
        exp_rsp_q.push_back({2'(id), d});
        tick();
      end
    end
    bus.mcif2sdp_rd_rsp_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"}, bus.cl_req_ready, 0);
    check({pfx, "_rsp_valid"}, bus.cl_rsp_valid, 0);
    check({pfx, "_mreq_valid"}, bus.sdp2mcif_rd_req_valid, 0);
    check({pfx, "_mreq_pd"}, bus.sdp2mcif_rd_req_pd, 0);
    check({pfx, "_mrsp_ready"}, bus.mcif2sdp_rd_rsp_ready, 0);
    check({pfx, "_outstanding"}, rd_outstanding, 0);
    check({pfx, "_rsp_err"}, rd_rsp_err, 0);
  endtask

  // Monitor: every transfer on either output channel is compared to the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sdp2mcif_rd_req_valid && bus.sdp2mcif_rd_req_ready) begin
        if (exp_req_q.size() == 0) fail_now("req_unexpected");
        else check("req_pd", bus.sdp2mcif_rd_req_pd, exp_req_q.pop_front());
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.cl_rsp_valid[i] && bus.cl_rsp_ready[i]) begin
          if (exp_rsp_q.size() == 0) fail_now("rsp_unexpected");
          else check("rsp_id_data", {2'(i), bus.cl_rsp_pd}, exp_rsp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [REQ_PD_W-1:0] held;
    logic [RSP_PD_W-1:0] d0;
    int                  id, sz;

    rst = 1'b1;
    bus.cl_req_valid          = '0;
    bus.cl_req_pd             = '0;
    bus.cl_rsp_ready          = '0;
    bus.sdp2mcif_rd_req_ready = 1'b0;
    bus.mcif2sdp_rd_rsp_valid = 1'b0;
    bus.mcif2sdp_rd_rsp_pd    = '0;
    for (int c = 0; c < NREQ; c++) sent[c] = 0;

    // Reset: requests pending must not be accepted
    repeat (2) @(posedge clk);
    #1;
    bus.cl_req_valid = 4'hF;
    drive_pds(0);
    mid();
    check_reset_outputs("rst");
    tick();
    bus.cl_req_valid          = '0;
    rst                       = 1'b0;
    bus.sdp2mcif_rd_req_ready = 1'b1;
    bus.cl_rsp_ready          = 4'hF;
    mid();
    check("post_rst_outstanding", rd_outstanding, 0);

    // 1: all clients valid, size 0: grants rotate one per cycle
    tick();
    bus.cl_req_valid = 4'hF;
    drive_pds(0);
    run_grants(0, 8, 0);
    bus.cl_req_valid = '0;
    mid();
    check("t1_outstanding_full", rd_outstanding, 8);
    tick();
    drain();
    mid();
    check("t1_outstanding_empty", rd_outstanding, 0);

    // 2: client 2, size 3, four response beats
    tick();
    bus.cl_req_valid = 4'b0100;
    drive_pds(3);
    mid();
    expect_grant(2, 3);
    tick();
    sent[2]++;
    bus.cl_req_valid = '0;
    mid();
    check("t2_outstanding_1", rd_outstanding, 1);
    tick();
    id = pend_id_q.pop_front();
    sz = pend_sz_q.pop_front();
    for (int b = 0; b <= sz; b++) begin
      d0 = rnd_data();
      bus.mcif2sdp_rd_rsp_valid = 1'b1;
      bus.mcif2sdp_rd_rsp_pd    = d0;
      exp_rsp_q.push_back({2'(id), d0});
      mid();
      check("t2_rsp_valid", bus.cl_rsp_valid, 4'b0100);
      check("t2_outstanding_held", rd_outstanding, 1);
      tick();
    end
    bus.mcif2sdp_rd_rsp_valid = 1'b0;
    mid();
    check("t2_outstanding_0", rd_outstanding, 0);

    // 3: fill all tags, stall MCIF, then one pop frees the ninth grant
    tick();
    bus.cl_req_valid = 4'hF;
    drive_pds(0);
    run_grants(3, 8, 0);
    bus.sdp2mcif_rd_req_ready = 1'b0;
    held = mk_pd(2, sent[2] - 1, 0);
    for (int k = 0; k < 3; k++) begin
      mid();
      check("t3_req_ready_full", bus.cl_req_ready, 0);
      check("t3_outstanding_8", rd_outstanding, 8);
      check("t3_mreq_valid_held", bus.sdp2mcif_rd_req_valid, 1);
      check("t3_mreq_pd_held", bus.sdp2mcif_rd_req_pd, held);
      tick();
    end
    bus.sdp2mcif_rd_req_ready = 1'b1;
    mid();
    check("t3_req_ready_full_drain", bus.cl_req_ready, 0);
    tick();
    id = pend_id_q.pop_front();
    sz = pend_sz_q.pop_front();
    d0 = rnd_data();
    bus.mcif2sdp_rd_rsp_valid = 1'b1;
    bus.mcif2sdp_rd_rsp_pd    = d0;
    exp_rsp_q.push_back({2'(id), d0});
    mid();
    check("t3_req_ready_before_pop", bus.cl_req_ready, 0);
    tick();
    bus.mcif2sdp_rd_rsp_valid = 1'b0;
    mid();
    expect_grant(3, 0);
    tick();
    sent[3]++;
    bus.cl_req_valid = '0;
    drive_pds(0);
    drain();
    mid();
    check("t3_outstanding_0", rd_outstanding, 0);

    // 4: client response back-pressure for 5 cycles
    tick();
    bus.cl_req_valid = 4'b0010;
    drive_pds(1);
    mid();
    expect_grant(1, 1);
    tick();
    sent[1]++;
    bus.cl_req_valid = '0;
    tick();
    id = pend_id_q.pop_front();
    sz = pend_sz_q.pop_front();
    bus.cl_rsp_ready          = 4'b1101;
    d0                        = rnd_data();
    bus.mcif2sdp_rd_rsp_valid = 1'b1;
    bus.mcif2sdp_rd_rsp_pd    = d0;
    for (int k = 0; k < 5; k++) begin
      mid();
      check("t4_mrsp_ready_low", bus.mcif2sdp_rd_rsp_ready, 0);
      check("t4_rsp_valid", bus.cl_rsp_valid, 4'b0010);
      check("t4_rsp_pd", bus.cl_rsp_pd, d0);
      tick();
    end
    bus.cl_rsp_ready = 4'hF;
    exp_rsp_q.push_back({2'(id), d0});
    mid();
    check("t4_mrsp_ready_high", bus.mcif2sdp_rd_rsp_ready, 1);
    tick();
    d0 = rnd_data();
    bus.mcif2sdp_rd_rsp_pd = d0;
    exp_rsp_q.push_back({2'(id), d0});
    tick();
    bus.mcif2sdp_rd_rsp_valid = 1'b0;
    mid();
    check("t4_outstanding_0", rd_outstanding, 0);

    // 5: response with no tag outstanding is dropped and flagged
    tick();
    bus.mcif2sdp_rd_rsp_valid = 1'b1;
    bus.mcif2sdp_rd_rsp_pd    = rnd_data();
    mid();
    check("t5_mrsp_ready", bus.mcif2sdp_rd_rsp_ready, 1);
    check("t5_rsp_valid_none", bus.cl_rsp_valid, 0);
    check("t5_err_before", rd_rsp_err, 0);
    tick();
    bus.mcif2sdp_rd_rsp_valid = 1'b0;
    mid();
    check("t5_err_set", rd_rsp_err, 1);
    check("t5_outstanding", rd_outstanding, 0);
    repeat (3) tick();
    mid();
    check("t5_err_sticky", rd_rsp_err, 1);

    // 6: reset with 3 tags outstanding and a burst half delivered
    tick();
    bus.cl_req_valid = 4'hF;
    drive_pds(2);
    run_grants(2, 3, 2);
    bus.cl_req_valid = '0;
    tick();
    id = pend_id_q.pop_front();
    sz = pend_sz_q.pop_front();
    d0 = rnd_data();
    bus.mcif2sdp_rd_rsp_valid = 1'b1;
    bus.mcif2sdp_rd_rsp_pd    = d0;
    exp_rsp_q.push_back({2'(id), d0});
    tick();
    bus.mcif2sdp_rd_rsp_valid = 1'b0;
    mid();
    check("t6_outstanding_3", rd_outstanding, 3);
    tick();
    bus.mcif2sdp_rd_rsp_valid = 1'b1;
    bus.mcif2sdp_rd_rsp_pd    = rnd_data();
    bus.cl_req_valid          = 4'hF;
    rst                       = 1'b1;
    pend_id_q.delete();
    pend_sz_q.delete();
    mid();
    check_reset_outputs("t6_rst");
    tick();
    bus.mcif2sdp_rd_rsp_valid = 1'b0;
    drive_pds(0);
    rst = 1'b0;
    mid();
    expect_grant(0, 0);
    tick();
    sent[0]++;
    bus.cl_req_valid = '0;
    tick();
    drain();
    mid();
    check("t6_outstanding_0", rd_outstanding, 0);
    check("t6_err_cleared", rd_rsp_err, 0);

    tick();
    mid();
    check("end_req_queue_empty", exp_req_q.size(), 0);
    check("end_rsp_queue_empty", exp_rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
